// File: rtl/player_update_scheduler.sv
// Per-frame sprite update scheduler for two players: latches joystick state on i_frame,
// computes clamped moves and fire events, and serialises two writes to the sprite store.
//
// state   | meaning
// IDLE    | waiting for i_frame
// CALC_A  | compute update for start player
// WRITE_A | present start player's write until accepted
// CALC_B  | compute update for the other player
// WRITE_B | present other player's write until accepted, then flip start player
module player_update_scheduler #(
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int STEP     = 2,
  parameter int COOLDOWN = 30,
  parameter int X0_INIT  = 64,
  parameter int Y_INIT   = 232
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame,
  input  logic [3:0] i_p0_dir,
  input  logic       i_p0_fire,
  input  logic [3:0] i_p1_dir,
  input  logic       i_p1_fire,
  output logic       o_wr_valid,
  input  logic       i_wr_ready,
  output logic       o_wr_player,
  output logic [9:0] o_wr_x,
  output logic [9:0] o_wr_y,
  output logic       o_wr_fire,
  output logic       o_busy,
  output logic       o_overrun
);

  localparam logic signed [10:0] X_LIM    = 11'(X_MAX - SPR_W + 1);
  localparam logic signed [10:0] Y_LIM    = 11'(Y_MAX - SPR_H + 1);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [9:0]         P0_X_RST = 10'(X0_INIT);
  localparam logic [9:0]         P1_X_RST = 10'(X_MAX - SPR_W + 1 - X0_INIT);
  localparam logic [9:0]         Y_RST    = 10'(Y_INIT);
  localparam logic [5:0]         CD_LOAD  = 6'(COOLDOWN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC_A  = 3'd1,
    WRITE_A = 3'd2,
    CALC_B  = 3'd3,
    WRITE_B = 3'd4
  } state_t;

  state_t     state;
  logic       start_ptr;
  logic [3:0] dir0_q, dir1_q;
  logic       fire0_q, fire1_q;
  logic [9:0] pos_x [2];
  logic [9:0] pos_y [2];
  logic [5:0] cd    [2];

  // Opposing presses cancel; inc/dec map to right/left or down/up.
  function automatic logic signed [10:0] axis_delta(input logic inc, input logic dec);
    if (inc && !dec)
      return STEP_S;
    else if (dec && !inc)
      return -STEP_S;
    else
      return 11'sd0;
  endfunction

  function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                       input logic signed [10:0] lim);
    if (v[10])
      return 10'd0;
    else if (v > lim)
      return lim[9:0];
    else
      return v[9:0];
  endfunction

  logic                cur_p;
  logic [3:0]          cur_dir;
  logic                cur_fire;
  logic [9:0]          cur_x, cur_y;
  logic signed [10:0]  sum_x, sum_y;
  logic [9:0]          nxt_x, nxt_y;
  logic                fire_ok;

  always_comb begin
    cur_p    = (state == CALC_B) ? ~start_ptr : start_ptr;
    cur_dir  = cur_p ? dir1_q : dir0_q;
    cur_fire = cur_p ? fire1_q : fire0_q;
    cur_x    = pos_x[cur_p];
    cur_y    = pos_y[cur_p];
    sum_x    = $signed({1'b0, cur_x}) + axis_delta(cur_dir[0], cur_dir[1]);
    sum_y    = $signed({1'b0, cur_y}) + axis_delta(cur_dir[2], cur_dir[3]);
    nxt_x    = clamp(sum_x, X_LIM);
    nxt_y    = clamp(sum_y, Y_LIM);
    fire_ok  = cur_fire && (cd[cur_p] == 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_ptr   <= 1'b0;
      dir0_q      <= 4'd0;
      dir1_q      <= 4'd0;
      fire0_q     <= 1'b0;
      fire1_q     <= 1'b0;
      pos_x[0]    <= P0_X_RST;
      pos_x[1]    <= P1_X_RST;
      pos_y[0]    <= Y_RST;
      pos_y[1]    <= Y_RST;
      cd[0]       <= 6'd0;
      cd[1]       <= 6'd0;
      o_wr_valid  <= 1'b0;
      o_wr_player <= 1'b0;
      o_wr_x      <= 10'd0;
      o_wr_y      <= 10'd0;
      o_wr_fire   <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= i_frame && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_frame) begin
            dir0_q  <= i_p0_dir;
            dir1_q  <= i_p1_dir;
            fire0_q <= i_p0_fire;
            fire1_q <= i_p1_fire;
            for (int i = 0; i < 2; i++)
              if (cd[i] != 6'd0)
                cd[i] <= cd[i] - 6'd1;
            o_busy <= 1'b1;
            state  <= CALC_A;
          end
        end
        CALC_A, CALC_B: begin
          pos_x[cur_p] <= nxt_x;
          pos_y[cur_p] <= nxt_y;
          if (fire_ok)
            cd[cur_p] <= CD_LOAD;
          o_wr_player <= cur_p;
          o_wr_x      <= nxt_x;
          o_wr_y      <= nxt_y;
          o_wr_fire   <= fire_ok;
          o_wr_valid  <= 1'b1;
          state       <= (state == CALC_A) ? WRITE_A : WRITE_B;
        end
        WRITE_A: begin
          if (i_wr_ready) begin
            o_wr_valid <= 1'b0;
            state      <= CALC_B;
          end
        end
        WRITE_B: begin
          if (i_wr_ready) begin
            o_wr_valid <= 1'b0;
            o_busy     <= 1'b0;
            start_ptr  <= ~start_ptr;
            state      <= IDLE;
          end
        end
        default: begin
          o_wr_valid <= 1'b0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_update_scheduler.sv
// Self-checking bench for player_update_scheduler: directed scenarios plus random frames,
// compared against a frame-level reference model of positions, cooldowns and write order.
module tb_player_update_scheduler;

  localparam int X_MAX = 639, Y_MAX = 479, SPR_W = 16, SPR_H = 16;
  localparam int STEP = 2, COOLDOWN = 30, X0_INIT = 64, Y_INIT = 232;
  localparam int X_LIM = X_MAX - SPR_W + 1;
  localparam int Y_LIM = Y_MAX - SPR_H + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_frame = 1'b0;
  logic [3:0] i_p0_dir = 4'd0, i_p1_dir = 4'd0;
  logic       i_p0_fire = 1'b0, i_p1_fire = 1'b0;
  logic       i_wr_ready = 1'b1;
  logic       o_wr_valid, o_wr_player, o_wr_fire, o_busy, o_overrun;
  logic [9:0] o_wr_x, o_wr_y;

  player_update_scheduler dut (
    .clk(clk), .rst(rst), .i_frame(i_frame),
    .i_p0_dir(i_p0_dir), .i_p0_fire(i_p0_fire),
    .i_p1_dir(i_p1_dir), .i_p1_fire(i_p1_fire),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
    .o_wr_player(o_wr_player), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y),
    .o_wr_fire(o_wr_fire), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // reference model state
  int mx[2], my[2], mcd[2], mstart;
  int e_p[2], e_x[2], e_y[2];
  bit e_f[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx[0] = X0_INIT; mx[1] = X_LIM - X0_INIT;
    my[0] = Y_INIT;  my[1] = Y_INIT;
    mcd[0] = 0; mcd[1] = 0; mstart = 0;
  endtask

  task automatic model_frame(input logic [3:0] d0, input logic f0,
                             input logic [3:0] d1, input logic f1);
    logic [3:0] d[2];
    logic f[2];
    int p, dx, dy, nx, ny;
    d[0] = d0; d[1] = d1; f[0] = f0; f[1] = f1;
    for (int i = 0; i < 2; i++) if (mcd[i] > 0) mcd[i] = mcd[i] - 1;
    for (int k = 0; k < 2; k++) begin
      p  = (k == 0) ? mstart : 1 - mstart;
      dx = 0; dy = 0;
      if (d[p][0] && !d[p][1]) dx = STEP; else if (d[p][1] && !d[p][0]) dx = -STEP;
      if (d[p][2] && !d[p][3]) dy = STEP; else if (d[p][3] && !d[p][2]) dy = -STEP;
      nx = mx[p] + dx; ny = my[p] + dy;
      if (nx < 0) nx = 0; if (nx > X_LIM) nx = X_LIM;
      if (ny < 0) ny = 0; if (ny > Y_LIM) ny = Y_LIM;
      mx[p] = nx; my[p] = ny;
      e_p[k] = p; e_x[k] = nx; e_y[k] = ny;
      e_f[k] = f[p] && (mcd[p] == 0);
      if (e_f[k]) mcd[p] = COOLDOWN;
    end
    mstart = 1 - mstart;
  endtask

  task automatic chk_write(input int k);
    chk($sformatf("player_%0d", k), 32'(o_wr_player), 32'(e_p[k]));
    chk($sformatf("x_%0d", k), 32'(o_wr_x), 32'(e_x[k]));
    chk($sformatf("y_%0d", k), 32'(o_wr_y), 32'(e_y[k]));
    chk($sformatf("fire_%0d", k), 32'(o_wr_fire), 32'(e_f[k]));
  endtask

  // One full frame sequence; stall >= 6 holds ready low in WRITE_A and injects an overrun.
  task automatic run_frame(input logic [3:0] d0, input logic f0,
                           input logic [3:0] d1, input logic f1, input int stall,
                           output logic fire0, output int x0, output int y0, output int x1);
    int cnt;
    model_frame(d0, f0, d1, f1);
    fire0 = 1'b0; x0 = -1; y0 = -1; x1 = -1;
    @(negedge clk);
    i_p0_dir = d0; i_p0_fire = f0; i_p1_dir = d1; i_p1_fire = f1;
    i_frame = 1'b1;
    i_wr_ready = (stall == 0);
    @(negedge clk);
    i_frame = 1'b0;
    i_p0_dir = 4'($urandom); i_p1_dir = 4'($urandom);
    i_p0_fire = 1'($urandom); i_p1_fire = 1'($urandom);
    chk("busy_set", 32'(o_busy), 1);
    cnt = 0;
    while (!o_wr_valid && cnt < 20) begin @(negedge clk); cnt++; end
    chk("valid_a", 32'(o_wr_valid), 1);
    if (stall == 0) chk("latency_a", cnt, 1);
    chk_write(0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      i_frame = (i == 3);
      chk("stall_valid", 32'(o_wr_valid), 1);
      chk_write(0);
      if (i == 4) chk("overrun_pulse", 32'(o_overrun), 1);
      if (i == 5) chk("overrun_clear", 32'(o_overrun), 0);
    end
    i_wr_ready = 1'b1;
    for (int k = 0; k < 2; k++) if (e_p[k] == 0) fire0 = e_f[k] ? o_wr_fire : o_wr_fire;
    if (o_wr_player == 1'b0) begin fire0 = o_wr_fire; x0 = o_wr_x; y0 = o_wr_y; end
    else x1 = o_wr_x;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!o_wr_valid && cnt < 20);
    chk("valid_b", 32'(o_wr_valid), 1);
    chk("latency_b", cnt, 2);
    chk_write(1);
    if (o_wr_player == 1'b0) begin fire0 = o_wr_fire; x0 = o_wr_x; y0 = o_wr_y; end
    else x1 = o_wr_x;
    @(negedge clk);
    chk("busy_clear", 32'(o_busy), 0);
    chk("valid_clear", 32'(o_wr_valid), 0);
    chk("no_overrun", 32'(o_overrun), 0);
  endtask

  initial begin
    logic f0s;
    int x0s, y0s, x1s, cnt;
    logic [3:0] rd0, rd1;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(o_wr_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_x", 32'(o_wr_x), 0);

    // first frame, no input: P0(64,232) then P1(560,232)
    run_frame(4'd0, 1'b0, 4'd0, 1'b0, 0, f0s, x0s, y0s, x1s);
    chk("first_p0_x", x0s, 64);
    chk("first_p1_x", x1s, 560);

    // P0 right held
    for (int k = 0; k < 3; k++) begin
      run_frame(4'b0001, 1'b0, 4'd0, 1'b0, 0, f0s, x0s, y0s, x1s);
      chk("p0_right_x", x0s, 66 + 2 * k);
    end

    // P1 right into the right edge, then held there
    for (int k = 0; k < 34; k++)
      run_frame(4'd0, 1'b0, 4'b0001, 1'b0, 0, f0s, x0s, y0s, x1s);
    chk("p1_right_clamp", x1s, 624);

    // P0 up into the top edge
    for (int k = 0; k < 118; k++)
      run_frame(4'b1000, 1'b0, 4'd0, 1'b0, 0, f0s, x0s, y0s, x1s);
    chk("p0_up_clamp", y0s, 0);

    // opposing presses cancel
    run_frame(4'b1111, 1'b0, 4'b0011, 1'b0, 0, f0s, x0s, y0s, x1s);
    chk("cancel_p0_x", x0s, 70);
    chk("cancel_p1_x", x1s, 624);

    // stalled WRITE_A with a dropped frame tick, then confirm no extra sequence
    run_frame(4'b0010, 1'b0, 4'b0100, 1'b0, 10, f0s, x0s, y0s, x1s);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_extra_valid", 32'(o_wr_valid), 0);
    end

    // reset during WRITE_B
    @(negedge clk);
    i_p0_dir = 4'b0001; i_p1_dir = 4'b0010; i_frame = 1'b1; i_wr_ready = 1'b1;
    @(negedge clk);
    i_frame = 1'b0;
    cnt = 0;
    while (!o_wr_valid && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    i_wr_ready = 1'b0;
    cnt = 0;
    while (!o_wr_valid && cnt < 20) begin @(negedge clk); cnt++; end
    chk("wb_reached", 32'(o_wr_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(o_wr_valid), 0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_x", 32'(o_wr_x), 0);
    chk("midrst_player", 32'(o_wr_player), 0);
    @(negedge clk);
    rst = 1'b0; i_wr_ready = 1'b1;
    model_reset();
    run_frame(4'd0, 1'b0, 4'd0, 1'b0, 0, f0s, x0s, y0s, x1s);
    chk("post_rst_p0_x", x0s, 64);
    chk("post_rst_p1_x", x1s, 560);

    // fire held 40 frames: accepted on frames 1 and 31
    for (int k = 1; k <= 40; k++) begin
      run_frame(4'd0, 1'b1, 4'd0, 1'b0, 0, f0s, x0s, y0s, x1s);
      chk($sformatf("fire_frame_%0d", k), 32'(f0s), 32'((k == 1) || (k == 31)));
    end

    // random frames
    for (int k = 0; k < 60; k++) begin
      rd0 = 4'($urandom);
      rd1 = 4'($urandom);
      run_frame(rd0, 1'($urandom), rd1, 1'($urandom),
                ($urandom_range(0, 4) == 0) ? 10 : 0, f0s, x0s, y0s, x1s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
